nes_cpu_bus_responder: RTL and testbench
========================================

Name: nes_cpu_bus_responder

Overview:
- Target-side responder for the 6502 core's memory bus; the CPU is the only initiator.
- Decodes each CPU address into internal 2 KB work RAM (mirrored), the PPU register window, the OAM-DMA trigger at $4014, or PRG ROM, and returns read data to the CPU.
- Runs the sprite OAM DMA engine, which stalls the CPU through its chip-enable while it copies 256 bytes into PPU register 4.

Parameters:
- RAM_BITS, 11, work-RAM address width; RAM is 2^RAM_BITS bytes, mirrored across $0000-$1FFF.
- ROM_BITS, 15, PRG ROM address width, mapped at $8000-$FFFF.
- DMA_ADDR, 16'h4014, write address that triggers OAM DMA.

Ports:
- pin_clock  in  1  system clock; all state changes on the rising edge.
- pin_reset  in  1  synchronous reset, active-high.
- cpu_address  in  16  CPU address.
- cpu_o  in  8  CPU write data.
- cpu_w  in  1  CPU write enable.
- cpu_read  in  1  CPU read strobe, one cycle per data read.
- cpu_i  out  8  read data to the CPU.
- cpu_ce  out  1  CPU chip-enable; 0 stalls the CPU.
- rom_address  out  ROM_BITS  PRG ROM address.
- rom_data  in  8  PRG ROM data, combinational from rom_address.
- ppu_reg  out  3  PPU register index.
- ppu_din  out  8  write data to the PPU.
- ppu_we  out  1  PPU register write strobe.
- ppu_re  out  1  PPU register read strobe; the PPU uses it for side effects.
- ppu_dout  in  8  PPU register read data.
- dma_busy  out  1  high while DMA owns the bus.

Behaviour:
- Reset: synchronous and active-high, sampled on the rising edge of pin_clock.
  - On reset: state=IDLE, cpu_ce=1, dma_busy=0, dma index=0, open-bus latch=8'h00, parity bit=0.
  - ppu_we and ppu_re are forced to 0 while pin_reset is high.
  - RAM contents are not cleared.
  - Reset asserted mid-DMA aborts the transfer; CPU is released (cpu_ce=1) on the reset edge.
- Decode (eff_addr = cpu_address when IDLE, DMA source address otherwise):
  - $0000-$1FFF: RAM[eff_addr[RAM_BITS-1:0]].
  - $2000-$3FFF: PPU, ppu_reg=eff_addr[2:0].
  - DMA_ADDR: write-only.
  - Other $4000-$7FFF: unmapped.
  - $8000-$FFFF: rom_address=eff_addr[ROM_BITS-1:0].
- Read path: cpu_i is combinational from the decode.
  - RAM: asynchronous read.
  - PPU: ppu_dout.
  - ROM: rom_data.
  - Unmapped and DMA_ADDR: open-bus latch.
- Open-bus latch: every clock with cpu_ce=1, it loads cpu_o on writes and the decoded read data on mapped reads.
- Writes: committed on the rising edge where cpu_w=1 and cpu_ce=1.
  - RAM write is synchronous.
  - ROM writes are ignored.
  - ppu_we = cpu_w & cpu_ce & PPU-range, with ppu_din=cpu_o.
  - ppu_re = cpu_read & ~cpu_w & cpu_ce & PPU-range.
- Parity bit toggles every clock after reset.
- DMA FSM states: IDLE, ALIGN, DREAD, DWRITE.
  - IDLE -> ALIGN: on a committed write to DMA_ADDR. Latch page=cpu_o, index=0. cpu_ce=0 and dma_busy=1 from the next cycle.
  - ALIGN: one dummy cycle. If parity=1 on leaving ALIGN, spend one more ALIGN cycle. Then go to DREAD.
  - DREAD: source = {page, index}. Capture the decoded byte into the data register. -> DWRITE.
  - DWRITE: ppu_reg=4, ppu_din=data register, ppu_we=1. Then:
    - index<255: index+1, go to DREAD.
    - index=255: go to IDLE; cpu_ce=1 and dma_busy=0 from the next cycle.
  - Total stall is 513 cycles (even start) or 514 cycles (odd start).
  - DMA source in the PPU or unmapped range returns the open-bus latch. ppu_re is never asserted during DMA.
  - All CPU inputs are ignored while dma_busy=1.
  - The open-bus latch holds its value during DMA.
- Index arithmetic is 8-bit. There is no wrap past 255; the transfer ends there.
- Back-to-back DMA: a write to DMA_ADDR on the first cycle after release starts a new transfer normally.

Test Plan:
- Reset then idle -> cpu_ce=1, dma_busy=0, ppu_we=0, ppu_re=0; read of $5000 returns 8'h00.
- Write 8'hA5 to $0005, then read $0805 and $1805 -> cpu_i=8'hA5 both times (mirroring). Read $5000 next -> 8'hA5 (open bus from last write).
- Read $8123 with rom_data=8'h3C -> rom_address=15'h0123, cpu_i=8'h3C. Write to $8123 -> RAM and PPU unchanged.
- Read $2002 with cpu_read=1 -> ppu_reg=2, ppu_re=1 for exactly one cycle, cpu_i=ppu_dout. Write 8'h80 to $3FF8 -> ppu_reg=0, ppu_we=1, ppu_din=8'h80.
- Fill RAM $0200-$02FF with i^8'h5A, then write 8'h02 to $4014 on an even and on an odd parity cycle:
  - Exactly 256 ppu_we pulses with ppu_reg=4 and data i^8'h5A in order.
  - cpu_ce low for 513 and 514 cycles respectively.
- Assert pin_reset at DMA index 100 -> next cycle cpu_ce=1, dma_busy=0, no further ppu_we. A new DMA afterwards starts at index 0.

Source files
------------

// File: rtl/nes_cpu_bus_responder.sv
// CPU-side bus responder: address decode for work RAM, PPU registers, OAM-DMA and PRG ROM,
// plus the sprite DMA engine that stalls the CPU while copying a 256-byte page into OAMDATA.
`timescale 1ns/1ps
module nes_cpu_bus_responder #(
  parameter int          RAM_BITS = 11,
  parameter int          ROM_BITS = 15,
  parameter logic [15:0] DMA_ADDR = 16'h4014
) (
  input  logic                pin_clock,
  input  logic                pin_reset,
  input  logic [15:0]         cpu_address,
  input  logic [7:0]          cpu_o,
  input  logic                cpu_w,
  input  logic                cpu_read,
  output logic [7:0]          cpu_i,
  output logic                cpu_ce,
  output logic [ROM_BITS-1:0] rom_address,
  input  logic [7:0]          rom_data,
  output logic [2:0]          ppu_reg,
  output logic [7:0]          ppu_din,
  output logic                ppu_we,
  output logic                ppu_re,
  input  logic [7:0]          ppu_dout,
  output logic                dma_busy
);

  typedef enum logic [1:0] {IDLE, ALIGN, DREAD, DWRITE} dma_state_t;

  dma_state_t  state_reg;
  logic        cpu_ce_reg;
  logic        dma_busy_reg;
  logic        parity_reg;
  logic [7:0]  page_reg;
  logic [7:0]  index_reg;
  logic [7:0]  data_reg;
  logic [7:0]  open_bus_reg;

  logic [7:0]  ram [2**RAM_BITS];

  logic        idle;
  logic [15:0] eff_addr;
  logic        sel_ram;
  logic        sel_ppu;
  logic        sel_rom;
  logic        sel_dma;
  logic        mapped;
  logic        cpu_wr_commit;
  logic        cpu_rd;
  logic [7:0]  read_data;

  assign idle     = (state_reg == IDLE);
  assign eff_addr = idle ? cpu_address : {page_reg, index_reg};

  assign sel_ram  = (eff_addr[15:13] == 3'b000);
  assign sel_ppu  = (eff_addr[15:13] == 3'b001);
  assign sel_rom  = eff_addr[15];
  assign sel_dma  = (eff_addr == DMA_ADDR);
  assign mapped   = sel_ram | sel_ppu | sel_rom;

  // CPU accesses only exist while the engine is idle; reset suppresses any commit.
  assign cpu_wr_commit = idle & cpu_ce_reg & cpu_w & ~pin_reset;
  assign cpu_rd        = idle & cpu_ce_reg & cpu_read & ~cpu_w;

  // The PPU is never read by the DMA engine, so a PPU-range source falls back to open bus.
  always_comb begin
    read_data = open_bus_reg;
    if (sel_ram)
      read_data = ram[eff_addr[RAM_BITS-1:0]];
    else if (sel_rom)
      read_data = rom_data;
    else if (sel_ppu && idle)
      read_data = ppu_dout;
  end

  assign cpu_i       = read_data;
  assign rom_address = eff_addr[ROM_BITS-1:0];
  assign cpu_ce      = cpu_ce_reg;
  assign dma_busy    = dma_busy_reg;

  assign ppu_reg = (state_reg == DWRITE) ? 3'd4 : eff_addr[2:0];
  assign ppu_din = (state_reg == DWRITE) ? data_reg : cpu_o;
  assign ppu_we  = ~pin_reset & ((cpu_wr_commit & sel_ppu) | (state_reg == DWRITE));
  assign ppu_re  = ~pin_reset & cpu_rd & sel_ppu;

  // Work RAM keeps its contents across reset.
  always_ff @(posedge pin_clock) begin
    if (cpu_wr_commit && sel_ram)
      ram[eff_addr[RAM_BITS-1:0]] <= cpu_o;
  end

  always_ff @(posedge pin_clock) begin
    if (pin_reset) begin
      state_reg    <= IDLE;
      cpu_ce_reg   <= 1'b1;
      dma_busy_reg <= 1'b0;
      parity_reg   <= 1'b0;
      page_reg     <= 8'h00;
      index_reg    <= 8'h00;
      data_reg     <= 8'h00;
      open_bus_reg <= 8'h00;
    end else begin
      parity_reg <= ~parity_reg;

      if (cpu_ce_reg && idle) begin
        if (cpu_w)
          open_bus_reg <= cpu_o;
        else if (cpu_read && mapped)
          open_bus_reg <= read_data;
      end

      case (state_reg)
        IDLE: begin
          if (cpu_wr_commit && sel_dma) begin
            page_reg     <= cpu_o;
            index_reg    <= 8'h00;
            state_reg    <= ALIGN;
            cpu_ce_reg   <= 1'b0;
            dma_busy_reg <= 1'b1;
          end
        end
        ALIGN: begin
          // Leave only when the edge out of ALIGN lands parity on 0; otherwise burn one more cycle.
          if (parity_reg)
            state_reg <= DREAD;
        end
        DREAD: begin
          data_reg  <= read_data;
          state_reg <= DWRITE;
        end
        DWRITE: begin
          if (index_reg == 8'hFF) begin
            state_reg    <= IDLE;
            cpu_ce_reg   <= 1'b1;
            dma_busy_reg <= 1'b0;
          end else begin
            index_reg <= index_reg + 8'd1;
            state_reg <= DREAD;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_cpu_bus_responder.sv
// Directed bench for nes_cpu_bus_responder: table of single-cycle bus vectors plus
// hand-written OAM-DMA sequences (even/odd start, back-to-back, reset abort).
`timescale 1ns/1ps
module tb_nes_cpu_bus_responder;

  logic        pin_clock = 1'b0;
  logic        pin_reset;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_o;
  logic        cpu_w;
  logic        cpu_read;
  logic [7:0]  cpu_i;
  logic        cpu_ce;
  logic [14:0] rom_address;
  logic [7:0]  rom_data;
  logic [2:0]  ppu_reg;
  logic [7:0]  ppu_din;
  logic        ppu_we;
  logic        ppu_re;
  logic [7:0]  ppu_dout;
  logic        dma_busy;

  int   n_vec  = 0;
  int   n_fail = 0;
  logic tb_par;

  always #5 pin_clock = ~pin_clock;

  // ROM model: data is address low byte + 0x19, so $8123 reads 0x3C.
  assign rom_data = rom_address[7:0] + 8'h19;

  always @(posedge pin_clock) tb_par <= pin_reset ? 1'b0 : ~tb_par;

  nes_cpu_bus_responder dut (
    .pin_clock   (pin_clock),
    .pin_reset   (pin_reset),
    .cpu_address (cpu_address),
    .cpu_o       (cpu_o),
    .cpu_w       (cpu_w),
    .cpu_read    (cpu_read),
    .cpu_i       (cpu_i),
    .cpu_ce      (cpu_ce),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .ppu_reg     (ppu_reg),
    .ppu_din     (ppu_din),
    .ppu_we      (ppu_we),
    .ppu_re      (ppu_re),
    .ppu_dout    (ppu_dout),
    .dma_busy    (dma_busy)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        w;
    logic        rd;
    logic        chk_i;
    logic [7:0]  exp_i;
    logic        exp_we;
    logic        exp_re;
    logic [2:0]  exp_reg;
    string       name;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_address = 16'h0000;
    cpu_o       = 8'h00;
    cpu_w       = 1'b0;
    cpu_read    = 1'b0;
  endtask

  // Called between a falling edge and the next rising edge; returns at the same phase.
  task automatic do_dma(input logic [7:0] page, input int abort_at, input string tag);
    int   exp_len;
    int   low;
    int   pulses;
    int   busy_bad;
    int   stray;
    logic re_seen;
    logic done;
    logic aborted;
    exp_len  = 513 + int'(tb_par);
    low      = 0;
    pulses   = 0;
    busy_bad = 0;
    re_seen  = 1'b0;
    done     = 1'b0;
    aborted  = 1'b0;
    cpu_address = 16'h4014;
    cpu_o       = page;
    cpu_w       = 1'b1;
    cpu_read    = 1'b0;
    @(negedge pin_clock);
    // Bus activity during the stall must be ignored.
    cpu_address = 16'h2002;
    cpu_o       = 8'h00;
    cpu_w       = 1'b0;
    cpu_read    = 1'b1;
    for (int c = 0; c < 700 && !done; c++) begin
      #2;
      if (cpu_ce === 1'b1) begin
        done = 1'b1;
      end else begin
        low++;
        if (dma_busy !== 1'b1) busy_bad++;
        if (ppu_re !== 1'b0) re_seen = 1'b1;
        if (ppu_we === 1'b1) begin
          check({tag, " dma_reg"}, 32'(ppu_reg), 32'd4);
          check({tag, " dma_data"}, 32'(ppu_din), 32'(8'(pulses) ^ 8'h5A));
          pulses++;
        end
        if (abort_at >= 0 && pulses == abort_at) begin
          @(negedge pin_clock);
          @(negedge pin_clock);
          pin_reset = 1'b1;
          #2;
          check({tag, " rst_we_forced"}, 32'(ppu_we), 32'd0);
          @(negedge pin_clock);
          pin_reset = 1'b0;
          idle_inputs();
          #2;
          check({tag, " rst_cpu_ce"}, 32'(cpu_ce), 32'd1);
          check({tag, " rst_dma_busy"}, 32'(dma_busy), 32'd0);
          stray = 0;
          repeat (20) begin
            @(negedge pin_clock);
            #2;
            if (ppu_we !== 1'b0) stray++;
          end
          check({tag, " rst_no_we"}, 32'(stray), 32'd0);
          aborted = 1'b1;
          done    = 1'b1;
        end else begin
          @(negedge pin_clock);
          if (low == 300) begin
            cpu_address = 16'h0250;
            cpu_o       = 8'h00;
            cpu_w       = 1'b1;
            cpu_read    = 1'b0;
          end
          if (low == 480) idle_inputs();
        end
      end
    end
    if (!done) check({tag, " release_timeout"}, 32'd0, 32'd1);
    if (!aborted) begin
      check({tag, " stall_len"}, 32'(low), 32'(exp_len));
      check({tag, " we_count"}, 32'(pulses), 32'd256);
      check({tag, " no_ppu_re"}, 32'(re_seen), 32'd0);
      check({tag, " busy_while_stalled"}, 32'(busy_bad), 32'd0);
    end
    $display("dma %s: stall %0d cycles (expected %0d), %0d OAM writes%s",
             tag, low, exp_len, pulses, aborted ? ", aborted by reset" : "");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'h5000, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, "openbus_reset"};
    vecs[1]  = '{16'h0005, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, "ram_wr_0005"};
    vecs[2]  = '{16'h0805, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 3'd5, "mirror_0805"};
    vecs[3]  = '{16'h1805, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 3'd5, "mirror_1805"};
    vecs[4]  = '{16'h5000, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 3'd0, "openbus_a5"};
    vecs[5]  = '{16'h0123, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, "ram_wr_0123"};
    vecs[6]  = '{16'h8123, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 3'd3, "rom_rd_8123"};
    vecs[7]  = '{16'h8123, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, "rom_wr_ignored"};
    vecs[8]  = '{16'h5000, 8'h00, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 3'd0, "openbus_rom_wr"};
    vecs[9]  = '{16'h0123, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 3'd3, "ram_kept_0123"};
    vecs[10] = '{16'h2002, 8'h00, 1'b0, 1'b1, 1'b1, 8'h6E, 1'b0, 1'b1, 3'd2, "ppu_rd_2002"};
    vecs[11] = '{16'h2002, 8'h00, 1'b0, 1'b0, 1'b1, 8'h6E, 1'b0, 1'b0, 3'd2, "ppu_re_one_cycle"};
    vecs[12] = '{16'h3FF8, 8'h80, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, "ppu_wr_3ff8"};
    vecs[13] = '{16'h4014, 8'h00, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 3'd4, "dma_reg_read"};
    vecs[14] = '{16'h4015, 8'h00, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 3'd5, "unmapped_4015"};
    vecs[15] = '{16'h2007, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd7, "ppu_wr_with_rd"};
    vecs[16] = '{16'h1FFF, 8'hC4, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd7, "ram_wr_1fff"};
    vecs[17] = '{16'h07FF, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC4, 1'b0, 1'b0, 3'd7, "mirror_07ff"};
    vecs[18] = '{16'hFFFF, 8'h00, 1'b0, 1'b1, 1'b1, 8'h18, 1'b0, 1'b0, 3'd7, "rom_rd_ffff"};

    ppu_dout = 8'h6E;
    idle_inputs();
    pin_reset = 1'b1;
    repeat (3) @(negedge pin_clock);
    pin_reset = 1'b0;
    #2;
    check("reset cpu_ce", 32'(cpu_ce), 32'd1);
    check("reset dma_busy", 32'(dma_busy), 32'd0);
    check("reset ppu_we", 32'(ppu_we), 32'd0);
    check("reset ppu_re", 32'(ppu_re), 32'd0);
    @(negedge pin_clock);

    for (int i = 0; i < 19; i++) begin
      cpu_address = vecs[i].addr;
      cpu_o       = vecs[i].wdata;
      cpu_w       = vecs[i].w;
      cpu_read    = vecs[i].rd;
      #2;
      check({vecs[i].name, " cpu_ce"}, 32'(cpu_ce), 32'd1);
      check({vecs[i].name, " ppu_we"}, 32'(ppu_we), 32'(vecs[i].exp_we));
      check({vecs[i].name, " ppu_re"}, 32'(ppu_re), 32'(vecs[i].exp_re));
      check({vecs[i].name, " ppu_reg"}, 32'(ppu_reg), 32'(vecs[i].exp_reg));
      if (vecs[i].chk_i)
        check({vecs[i].name, " cpu_i"}, 32'(cpu_i), 32'(vecs[i].exp_i));
      if (vecs[i].exp_we)
        check({vecs[i].name, " ppu_din"}, 32'(ppu_din), 32'(vecs[i].wdata));
      if (vecs[i].addr[15])
        check({vecs[i].name, " rom_address"}, 32'(rom_address), 32'(vecs[i].addr[14:0]));
      $display("vec %0d %s: addr %04h w=%0b rd=%0b cpu_i=%02h we=%0b re=%0b reg=%0d",
               i, vecs[i].name, vecs[i].addr, vecs[i].w, vecs[i].rd, cpu_i, ppu_we, ppu_re, ppu_reg);
      @(negedge pin_clock);
    end

    for (int i = 0; i < 256; i++) begin
      cpu_address = 16'h0200 + 16'(i);
      cpu_o       = 8'(i) ^ 8'h5A;
      cpu_w       = 1'b1;
      cpu_read    = 1'b0;
      @(negedge pin_clock);
    end
    idle_inputs();
    $display("fill: RAM $0200-$02FF loaded with i^5A");

    while (tb_par !== 1'b0) @(negedge pin_clock);
    do_dma(8'h02, -1, "even");
    @(negedge pin_clock);
    while (tb_par !== 1'b1) @(negedge pin_clock);
    do_dma(8'h02, -1, "odd");
    do_dma(8'h02, -1, "back_to_back");
    @(negedge pin_clock);
    do_dma(8'h02, 100, "abort");
    @(negedge pin_clock);
    do_dma(8'h02, -1, "after_abort");
    @(negedge pin_clock);

    cpu_address = 16'h0250;
    cpu_read    = 1'b1;
    #2;
    check("ram_0250_untouched_by_stalled_write", 32'(cpu_i), 32'h0A);
    $display("post-dma read $0250 -> %02h", cpu_i);
    @(negedge pin_clock);
    cpu_address = 16'h0200;
    #2;
    check("ram_0200_after_dma", 32'(cpu_i), 32'h5A);
    $display("post-dma read $0200 -> %02h", cpu_i);
    @(negedge pin_clock);
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
